// File: rtl/mdu.sv
// Multiply/divide unit with private HI/LO registers for the pipelined MIPS core.
// Results are computed at issue and held in pending registers until the busy countdown expires.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic signed [WIDTH-1:0]   dvd_s, dvs_s, quo_s, rem_s;
    logic        [WIDTH-1:0]   dvs_u, quo_u, rem_u;
    logic                      div_zero, div_ovf;

    assign prod_s = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a}) *
                    $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
    assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    // Dividing MOST_NEG by 1 instead of -1 yields exactly the defined overflow result
    // (quotient MOST_NEG, remainder 0); a zero divisor is replaced so the divider never sees it.
    assign div_zero = (src_b == '0);
    assign div_ovf  = (src_a == MOST_NEG) && (src_b == '1);
    assign dvd_s    = $signed(src_a);
    assign dvs_s    = (div_zero || div_ovf) ? $signed(WIDTH'(1)) : $signed(src_b);
    assign quo_s    = dvd_s / dvs_s;
    assign rem_s    = dvd_s % dvs_s;
    assign dvs_u    = div_zero ? WIDTH'(1) : src_b;
    assign quo_u    = src_a / dvs_u;
    assign rem_u    = src_a % dvs_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_t'(mdu_op))
                        OP_MULT: begin
                            p_hi_d  = prod_s[2*WIDTH-1:WIDTH];
                            p_lo_d  = prod_s[WIDTH-1:0];
                            cnt_d   = MULT_CNT;
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            p_hi_d  = prod_u[2*WIDTH-1:WIDTH];
                            p_lo_d  = prod_u[WIDTH-1:0];
                            cnt_d   = MULT_CNT;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still runs the full latency but commits the old HI/LO.
                            if (div_zero) begin
                                p_hi_d = hi_q;
                                p_lo_d = lo_q;
                            end else if (op_t'(mdu_op) == OP_DIV) begin
                                p_hi_d = rem_s;
                                p_lo_d = quo_s;
                            end else begin
                                p_hi_d = rem_u;
                                p_lo_d = quo_u;
                            end
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the driver queues expected HI/LO/busy-length per operation,
// and a negedge monitor compares on completion (busy falling) or on the cycle after an immediate op.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        imm;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cycles;
        logic [31:0] id;
    } exp_t;

    exp_t check_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_len = 0;
    int   idle_wait = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL t%0d %s: got 0x%08h, expected 0x%08h", id, name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) run_len++;
        if (check_q.size() > 0) begin
            e = check_q[0];
            if (e.imm) begin
                void'(check_q.pop_front());
                chk("hi", e.id, hi, e.hi);
                chk("lo", e.id, lo, e.lo);
                chk("busy", e.id, {31'd0, busy}, 32'd0);
            end else if (busy !== 1'b1) begin
                if (run_len > 0) begin
                    void'(check_q.pop_front());
                    chk("hi", e.id, hi, e.hi);
                    chk("lo", e.id, lo, e.lo);
                    chk("busy_cycles", e.id, 32'(run_len), e.cycles);
                    idle_wait = 0;
                end else begin
                    idle_wait++;
                    if (idle_wait > 20) begin
                        void'(check_q.pop_front());
                        chk("busy_never_rose", e.id, 32'd0, 32'd1);
                        idle_wait = 0;
                    end
                end
            end else if (run_len > 100) begin
                void'(check_q.pop_front());
                chk("busy_stuck", e.id, 32'(run_len), e.cycles);
            end
        end
        if (busy !== 1'b1) run_len = 0;
        prev_busy = busy;
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        mdu_op = op;
        src_a  = a;
        src_b  = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 3'd0;
    endtask

    task automatic push(input logic imm, input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] cyc, input logic [31:0] id);
        exp_t e;
        e.imm = imm; e.hi = h; e.lo = l; e.cycles = cyc; e.id = id;
        check_q.push_back(e);
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (check_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (check_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", check_q.size());
            check_q.delete();
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 3'd0;
        src_a  = '0;
        src_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push(1'b1, 32'h0, 32'h0, 0, 1);
        wait_empty();

        // op none and reserved: no change
        issue(3'd0, 32'hDEADBEEF, 32'h1); push(1'b1, 32'h0, 32'h0, 0, 2); wait_empty();
        issue(3'd7, 32'hDEADBEEF, 32'h1); push(1'b1, 32'h0, 32'h0, 0, 3); wait_empty();

        // multiplies
        issue(3'd1, 32'hFFFFFFFF, 32'h2); push(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 4); wait_empty();
        issue(3'd2, 32'hFFFFFFFF, 32'h2); push(1'b0, 32'h00000001, 32'hFFFFFFFE, 5, 5); wait_empty();
        issue(3'd1, 32'hFFFFFFFD, 32'h5); push(1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 6); wait_empty();

        // divides
        issue(3'd3, 32'hFFFFFFF9, 32'h2);        push(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 7); wait_empty();
        issue(3'd4, 32'h7, 32'h2);               push(1'b0, 32'h1, 32'h3, 10, 8);               wait_empty();
        issue(3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE); push(1'b0, 32'hFFFFFFFF, 32'h3, 10, 9);        wait_empty();
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF); push(1'b0, 32'h0, 32'h80000000, 10, 10);       wait_empty();

        // mthi/mtlo then divide by zero
        issue(3'd5, 32'h1234, 32'h0); push(1'b1, 32'h1234, 32'h80000000, 0, 11); wait_empty();
        issue(3'd6, 32'h5678, 32'h0); push(1'b1, 32'h1234, 32'h5678, 0, 12);     wait_empty();
        issue(3'd4, 32'h5, 32'h0);    push(1'b0, 32'h1234, 32'h5678, 10, 13);    wait_empty();

        // issues while busy are ignored
        issue(3'd1, 32'h3, 32'h4); push(1'b0, 32'h0, 32'hC, 5, 14);
        issue(3'd6, 32'hAAAA, 32'h0);
        issue(3'd1, 32'h9, 32'h9);
        wait_empty();
        issue(3'd6, 32'hAAAA, 32'h0); push(1'b1, 32'h0, 32'hAAAA, 0, 15); wait_empty();

        // reset during the 4th busy cycle of a divide
        issue(3'd3, 32'd100, 32'd3); push(1'b0, 32'h0, 32'h0, 4, 16);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_empty();
        repeat (12) @(posedge clk);
        #1;
        push(1'b1, 32'h0, 32'h0, 0, 17);
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
